decode_queue: RTL
=================

Name: decode_queue

Overview:
- Parametrised instruction buffer between fetch and decode, replacing the single fetch/decode latch with a DEPTH-entry circular queue.
- Fetch can run ahead while decode is frozen, so fetch is only throttled when the queue is full.
- Honors pipeline flush (squash all entries) and freeze (hold the head), and carries an opaque WIDTH-bit packed fetch bus.
- Optional fall-through mode lets an entry bypass the queue when it is empty.

Parameters:
- WIDTH, 64, bit width of the packed fetch bus (instruction plus PC fields).
- DEPTH, 4, number of entries; power of two, at least 2.
- FALLTHROUGH, 0, when 1, an empty queue forwards in_data to out_data combinationally in the same cycle.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- ihit  input  1  instruction cache hit; qualifies in_valid.
- flush  input  1  squash all queued entries (branch/jump resolution).
- freeze  input  1  hold the head entry; blocks dequeue.
- in_valid  input  1  fetch presents an entry.
- in_data  input  WIDTH  packed fetch bus.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry is valid.
- out_data  output  WIDTH  head entry (packed fetch bus).
- out_ready  input  1  decode advances this cycle.
- count  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- Reset: asynchronous, active-low. While nRST=0 and after release:
  - read pointer and write pointer = 0, count = 0.
  - out_valid = 0, in_ready = 1, out_data = 0.
  - Storage contents are don't-care but must not be visible while out_valid = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH (DEPTH-1 to 0) with no extra logic.
- Full = (count == DEPTH). Empty = (count == 0).
- Definitions:
  - enq = in_valid & ihit & in_ready & ~flush.
  - deq = out_valid & out_ready & ~freeze & ~flush.
- in_ready:
  - in_ready = ~full, combinational from state only (no path from out_ready).
  - Consequence: a full queue refuses a new entry even when a dequeue happens in the same cycle.
- Normal mode (FALLTHROUGH=0):
  - out_valid = ~empty; out_data = mem[rd_ptr].
  - An entry enqueued in cycle N is visible at out_data in cycle N+1 at the earliest.
  - enq: write mem[wr_ptr], increment wr_ptr.
  - deq: increment rd_ptr.
  - count changes by +1 (enq only), -1 (deq only), or 0 (both or neither).
- Fall-through mode (FALLTHROUGH=1), when empty:
  - out_valid = in_valid & ihit & ~flush; out_data = in_data.
  - If deq occurs in the same cycle, the entry is consumed and not stored; pointers and count are unchanged.
  - If it is not consumed, the entry is stored as a normal enq.
  - When not empty, this mode behaves exactly like normal mode.
- Flush has highest priority:
  - On a clocked cycle with flush=1: rd_ptr = wr_ptr = 0, count = 0. Any simultaneous enq or deq is discarded.
  - out_valid is forced to 0 combinationally in the flush cycle.
  - in_ready follows ~full in the flush cycle and reads 1 the cycle after.
- Freeze:
  - Holds rd_ptr and out_data stable.
  - Enqueue continues while not full.
  - flush together with freeze: flush wins.
- ihit=0: no enqueue regardless of in_valid; in fall-through mode out_valid stays 0 when empty.
- Reset asserted mid-operation: all state clears immediately (asynchronous); no partial entry survives.
- No output may depend combinationally on out_ready.

Test Plan:
1. Reset, then enqueue 0xA, 0xB, 0xC, 0xD (DEPTH=4, ihit=1, out_ready=0) -> count goes 1, 2, 3, 4; in_ready=0 after the 4th; out_data=0xA throughout.
2. Full queue, in_valid=1 with 0xE, out_ready=1 for 1 cycle -> 0xE is rejected; head advances to 0xB; count=3; the next cycle accepts 0xE.
3. Wrap-around: perform 6 enqueue/dequeue pairs of 0x10..0x15 with simultaneous enq and deq each cycle -> count stays 1; out_data sequence 0x10..0x15 in order; pointers wrap past 3.
4. Queue holds 0x1, 0x2, 0x3; assert flush with in_valid=1 (0x9) and out_ready=1 -> next cycle count=0, out_valid=0, and 0x9 does not appear.
5. freeze=1 for 3 cycles with out_ready=1 while enqueuing 0x20, 0x21 -> out_data is held at the prior head; count rises by 2; on release the order is preserved.
6. FALLTHROUGH=1, empty queue, in_valid=ihit=out_ready=1 with 0x55 -> out_valid=1 and out_data=0x55 in the same cycle; count stays 0. Repeat with out_ready=0 -> count=1 and 0x55 is held at out_data.

Source files
------------

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular queue with flush,
// freeze, and an optional fall-through path for an empty queue.
module decode_queue #(
   parameter int WIDTH       = 64,
   parameter int DEPTH       = 4,
   parameter int FALLTHROUGH = 0
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       ihit,
   input  logic                       flush,
   input  logic                       freeze,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic empty, full, fetch_v, bypass;
   logic enq, deq, consumed, do_wr, do_rd;

   // Handshake: a transfer happens on a side when its valid and ready are both
   // high at the rising edge. in_ready depends on stored state only, and no
   // output has a combinational path from out_ready.
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == FULL_CNT);
      fetch_v = in_valid & ihit;
      bypass  = (FALLTHROUGH != 0) & empty;

      in_ready  = ~full;
      out_valid = ~flush & (empty ? (bypass & fetch_v) : 1'b1);
      out_data  = '0;
      if (out_valid) begin
         out_data = empty ? in_data : mem_q[rd_ptr_q];
      end
      count = count_q;
   end

   // A bypassed entry consumed in the same cycle never touches storage.
   always_comb begin
      enq      = fetch_v & in_ready & ~flush;
      deq      = out_valid & out_ready & ~freeze & ~flush;
      consumed = bypass & deq;
      do_wr    = enq & ~consumed;
      do_rd    = deq & ~consumed;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: out_data is gated whenever out_valid is low.
   always_ff @(posedge CLK) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule
